// File: rtl/video_ast_pkg.sv
// Shared definitions for the Avalon-ST video field arbiter: packet types,
// grant-mode encodings and the arbiter state enum.
package video_ast_pkg;

    localparam logic [3:0] PKT_CTRL  = 4'hF;
    localparam logic [3:0] PKT_VIDEO = 4'h0;

    localparam logic [1:0] MODE_FIXED0    = 2'd0;
    localparam logic [1:0] MODE_FIXED1    = 2'd1;
    localparam logic [1:0] MODE_ALT_FIELD = 2'd2;
    localparam logic [1:0] MODE_ALT_FRAME = 2'd3;

    typedef enum logic [2:0] {
        S_ARB,
        S_WAIT_CTRL,
        S_CTRL,
        S_WAIT_VID,
        S_VIDEO
    } state_t;

endpackage

// File: rtl/ast_pkt_monitor.sv
// Per-input start-of-packet decoder: flags a valid sop beat and whether it
// opens a control or a video packet.
module ast_pkt_monitor
    import video_ast_pkg::*;
(
    input  logic       valid,
    input  logic       sop,
    input  logic [3:0] pkt_type,
    output logic       is_sop,
    output logic       is_ctrl,
    output logic       is_video
);

    assign is_sop   = valid & sop;
    assign is_ctrl  = is_sop & (pkt_type == PKT_CTRL);
    assign is_video = is_sop & (pkt_type == PKT_VIDEO);

endmodule

// File: rtl/ast_field_arbiter.sv
// Two-input Avalon-ST video arbiter that forwards whole fields (control packet
// followed by video packet) and re-arbitrates only at field boundaries.
module ast_field_arbiter
    import video_ast_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DROP_UNGRANTED = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_valid,
    input  logic                  in0_startofpacket,
    input  logic                  in0_endofpacket,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    input  logic                  in1_startofpacket,
    input  logic                  in1_endofpacket,
    output logic                  in1_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    output logic                  grant,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  field_cnt
);

    localparam logic UNGRANTED_READY = (DROP_UNGRANTED != 0);

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  alt_q, alt_d;
    logic                  phase_q, phase_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  in0_is_sop, in0_is_ctrl, in0_is_video;
    logic                  in1_is_sop, in1_is_ctrl, in1_is_video;
    logic                  g_valid, g_sop, g_eop;
    logic                  g_is_sop, g_is_ctrl, g_is_video;
    logic [DATA_WIDTH-1:0] g_data;

    logic                  out_valid, out_sop, out_eop, take;
    logic [DATA_WIDTH-1:0] out_data;

    ast_pkt_monitor u_mon0 (
        .valid    (in0_valid),
        .sop      (in0_startofpacket),
        .pkt_type (in0_data[3:0]),
        .is_sop   (in0_is_sop),
        .is_ctrl  (in0_is_ctrl),
        .is_video (in0_is_video)
    );

    ast_pkt_monitor u_mon1 (
        .valid    (in1_valid),
        .sop      (in1_startofpacket),
        .pkt_type (in1_data[3:0]),
        .is_sop   (in1_is_sop),
        .is_ctrl  (in1_is_ctrl),
        .is_video (in1_is_video)
    );

    assign g_data     = grant_q ? in1_data          : in0_data;
    assign g_valid    = grant_q ? in1_valid         : in0_valid;
    assign g_sop      = grant_q ? in1_startofpacket : in0_startofpacket;
    assign g_eop      = grant_q ? in1_endofpacket   : in0_endofpacket;
    assign g_is_sop   = grant_q ? in1_is_sop        : in0_is_sop;
    assign g_is_ctrl  = grant_q ? in1_is_ctrl       : in0_is_ctrl;
    assign g_is_video = grant_q ? in1_is_video      : in0_is_video;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        alt_d     = alt_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        take      = 1'b0;

        case (state_q)
            S_ARB: begin
                case (mode)
                    MODE_FIXED0: grant_d = 1'b0;
                    MODE_FIXED1: grant_d = 1'b1;
                    MODE_ALT_FIELD: begin
                        grant_d = alt_q;
                        alt_d   = ~alt_q;
                    end
                    MODE_ALT_FRAME: begin
                        grant_d = alt_q;
                        phase_d = ~phase_q;
                        if (phase_q) alt_d = ~alt_q;
                    end
                    default: grant_d = 1'b0;
                endcase
                state_d = S_WAIT_CTRL;
            end

            S_WAIT_CTRL: begin
                if (g_is_ctrl) begin
                    out_valid = 1'b1;
                    out_data  = g_data;
                    out_sop   = 1'b1;
                    out_eop   = g_eop;
                    take      = dout_ready;
                    if (dout_ready) state_d = g_eop ? S_WAIT_VID : S_CTRL;
                end else begin
                    take  = 1'b1;
                    err_d = g_is_sop;
                end
            end

            S_WAIT_VID: begin
                if (g_is_video) begin
                    out_valid = 1'b1;
                    out_data  = g_data;
                    out_sop   = 1'b1;
                    out_eop   = g_eop;
                    take      = dout_ready;
                    // A one-beat video packet closes the field immediately.
                    if (dout_ready && g_eop) begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        state_d = S_ARB;
                    end else if (dout_ready) begin
                        state_d = S_VIDEO;
                    end
                end else begin
                    take  = 1'b1;
                    err_d = g_is_sop;
                end
            end

            S_CTRL, S_VIDEO: begin
                if (g_is_sop) begin
                    // Close the open packet with a filler eop; the sop beat waits.
                    out_valid = 1'b1;
                    out_eop   = 1'b1;
                    if (dout_ready) begin
                        err_d   = 1'b1;
                        state_d = S_ARB;
                    end
                end else begin
                    out_valid = g_valid;
                    out_data  = g_data;
                    out_eop   = g_eop;
                    take      = dout_ready;
                    if (g_valid && dout_ready && g_eop) begin
                        if (state_q == S_CTRL) begin
                            state_d = S_WAIT_VID;
                        end else begin
                            cnt_d   = cnt_q + CNT_WIDTH'(1);
                            state_d = S_ARB;
                        end
                    end
                end
            end

            default: state_d = S_ARB;
        endcase

        if (!out_valid) begin
            out_data = '0;
            out_sop  = 1'b0;
            out_eop  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_ARB;
            grant_q <= 1'b0;
            alt_q   <= 1'b0;
            phase_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            alt_q   <= alt_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_valid         = out_valid;
    assign dout_data          = out_data;
    assign dout_startofpacket = out_sop;
    assign dout_endofpacket   = out_eop;
    assign in0_ready          = grant_q ? UNGRANTED_READY : take;
    assign in1_ready          = grant_q ? take : UNGRANTED_READY;
    assign grant              = grant_q;
    assign err_pulse          = err_q;
    assign field_cnt          = cnt_q;

endmodule

// File: tb/tb_ast_field_arbiter.sv
// Scoreboard bench for ast_field_arbiter: queue-fed sources, expected output
// beats queued at stimulus time and popped by an independent monitor.
module tb_ast_field_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    logic       clock;
    logic       reset;
    logic [1:0] mode;
    logic [7:0] in0_data, in1_data, dout_data;
    logic       in0_valid, in0_startofpacket, in0_endofpacket, in0_ready;
    logic       in1_valid, in1_startofpacket, in1_endofpacket, in1_ready;
    logic       dout_valid, dout_startofpacket, dout_endofpacket, dout_ready;
    logic       grant, err_pulse;
    logic [2:0] field_cnt;

    beat_t src0_q[$];
    beat_t src1_q[$];
    beat_t exp_q[$];
    bit    hs0, hs1;
    bit    rand_en;
    int    n_compared;
    int    n_mismatched;
    int    err_seen;

    ast_field_arbiter #(
        .DATA_WIDTH     (8),
        .DROP_UNGRANTED (0),
        .CNT_WIDTH      (3)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mode               (mode),
        .in0_data           (in0_data),
        .in0_valid          (in0_valid),
        .in0_startofpacket  (in0_startofpacket),
        .in0_endofpacket    (in0_endofpacket),
        .in0_ready          (in0_ready),
        .in1_data           (in1_data),
        .in1_valid          (in1_valid),
        .in1_startofpacket  (in1_startofpacket),
        .in1_endofpacket    (in1_endofpacket),
        .in1_ready          (in1_ready),
        .dout_data          (dout_data),
        .dout_valid         (dout_valid),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket),
        .dout_ready         (dout_ready),
        .grant              (grant),
        .err_pulse          (err_pulse),
        .field_cnt          (field_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Queue one beat on a source; fwd says whether it must appear on dout.
    task automatic applyStimulus(input int src, input logic [7:0] d, input bit s,
                                 input bit e, input bit fwd);
        beat_t b;
        b = '{data: d, sop: s, eop: e};
        if (src == 0) src0_q.push_back(b);
        else          src1_q.push_back(b);
        if (fwd) exp_q.push_back(b);
    endtask

    task automatic addPkt(input int src, input logic [7:0] sop_byte, input int len,
                          input bit close, input logic [7:0] base, input bit fwd);
        for (int i = 0; i < len; i++)
            applyStimulus(src, (i == 0) ? sop_byte : base + 8'(i), i == 0,
                          close && (i == len - 1), fwd);
    endtask

    task automatic addField(input int src, input logic [7:0] base, input int vlen,
                            input bit fwd);
        addPkt(src, base | 8'h0F, 3, 1'b1, base, fwd);
        addPkt(src, base & 8'hF0, vlen, 1'b1, base + 8'h40, fwd);
    endtask

    task automatic expectFiller();
        exp_q.push_back('{data: 8'h00, sop: 1'b0, eop: 1'b1});
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic applyReset(input logic [1:0] m);
        tick();
        mode  = m;
        reset = 1'b1;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        tick();
        tick();
        reset    = 1'b0;
        err_seen = 0;
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput("drain_left", exp_q.size(), 0);
        repeat (4) tick();
    endtask

    // Source drivers: pop on the previous handshake, present the next head.
    always begin : src_driver
        beat_t b;
        @(negedge clock);
        if (hs0 && src0_q.size() != 0) void'(src0_q.pop_front());
        if (hs1 && src1_q.size() != 0) void'(src1_q.pop_front());
        if (src0_q.size() != 0 && (!rand_en || $urandom_range(0, 1) == 1)) begin
            b = src0_q[0];
            in0_valid = 1'b1;
            in0_data = b.data;
            in0_startofpacket = b.sop;
            in0_endofpacket = b.eop;
        end else begin
            in0_valid = 1'b0;
            in0_data = 8'h00;
            in0_startofpacket = 1'b0;
            in0_endofpacket = 1'b0;
        end
        if (src1_q.size() != 0 && (!rand_en || $urandom_range(0, 1) == 1)) begin
            b = src1_q[0];
            in1_valid = 1'b1;
            in1_data = b.data;
            in1_startofpacket = b.sop;
            in1_endofpacket = b.eop;
        end else begin
            in1_valid = 1'b0;
            in1_data = 8'h00;
            in1_startofpacket = 1'b0;
            in1_endofpacket = 1'b0;
        end
        dout_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        #4;
        hs0 = in0_valid && in0_ready;
        hs1 = in1_valid && in1_ready;
    end

    always begin : monitor
        beat_t e;
        @(negedge clock);
        #4;
        if (err_pulse === 1'b1) err_seen++;
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", {dout_data, dout_startofpacket, dout_endofpacket}, 32'h3FF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("dout_beat", {dout_data, dout_startofpacket, dout_endofpacket}, 32'(e));
            end
        end
        if (dout_valid !== 1'b1) checkOutput("idle_data", dout_data, 0);
        checkOutput("ungranted_ready", in0_ready & in1_ready, 0);
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared = 0; n_mismatched = 0; err_seen = 0;
        rand_en = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
        reset = 1'b1; mode = 2'd0; dout_ready = 1'b1;
        in0_valid = 1'b0; in0_data = 8'h00; in0_startofpacket = 1'b0; in0_endofpacket = 1'b0;
        in1_valid = 1'b0; in1_data = 8'h00; in1_startofpacket = 1'b0; in1_endofpacket = 1'b0;

        tick();
        tick();
        checkOutput("rst_dout_valid", dout_valid, 0);
        checkOutput("rst_dout_sop", dout_startofpacket, 0);
        checkOutput("rst_dout_eop", dout_endofpacket, 0);
        checkOutput("rst_dout_data", dout_data, 0);
        checkOutput("rst_err", err_pulse, 0);
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_field_cnt", field_cnt, 0);
        checkOutput("rst_in0_ready", in0_ready, 0);
        checkOutput("rst_in1_ready", in1_ready, 0);

        $display("[TB] mode 0: in0 ctrl + video, in1 idle");
        applyReset(2'd0);
        addPkt(0, 8'h0F, 10, 1'b1, 8'h10, 1'b1);
        addPkt(0, 8'h00, 40, 1'b1, 8'h30, 1'b1);
        waitDrain(500);
        checkOutput("m0_field_cnt", field_cnt, 1);
        checkOutput("m0_err", err_seen, 0);
        checkOutput("m0_grant", grant, 0);

        $display("[TB] mode 1: in1 forwarded, in0 held off");
        applyReset(2'd1);
        addField(0, 8'h20, 5, 1'b0);
        addField(1, 8'hC0, 6, 1'b1);
        waitDrain(300);
        checkOutput("m1_field_cnt", field_cnt, 1);
        checkOutput("m1_err", err_seen, 0);
        checkOutput("m1_grant", grant, 1);

        $display("[TB] mode 2: alternate per field");
        applyReset(2'd2);
        addField(0, 8'h10, 8, 1'b1);
        addField(1, 8'h90, 8, 1'b1);
        addField(0, 8'h20, 8, 1'b1);
        addField(1, 8'hA0, 8, 1'b1);
        waitDrain(500);
        checkOutput("m2_field_cnt", field_cnt, 4);
        checkOutput("m2_err", err_seen, 0);

        $display("[TB] mode 3: alternate per frame");
        applyReset(2'd3);
        addField(0, 8'h10, 7, 1'b1);
        addField(0, 8'h20, 7, 1'b1);
        addField(1, 8'h90, 7, 1'b1);
        addField(1, 8'hA0, 7, 1'b1);
        waitDrain(500);
        checkOutput("m3_field_cnt", field_cnt, 4);
        checkOutput("m3_err", err_seen, 0);

        $display("[TB] mid-stream start and stray sop beats");
        applyReset(2'd0);
        applyStimulus(0, 8'h33, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 8'h34, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 8'h35, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 8'h20, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 8'h0F, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, 8'hA5, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 8'h11, 1'b0, 1'b0, 1'b0);
        addPkt(0, 8'h30, 6, 1'b1, 8'h60, 1'b1);
        waitDrain(300);
        checkOutput("mid_field_cnt", field_cnt, 1);
        checkOutput("mid_err", err_seen, 2);

        $display("[TB] truncation in video and control packets");
        applyReset(2'd0);
        addPkt(0, 8'h0F, 4, 1'b1, 8'h10, 1'b1);
        addPkt(0, 8'h00, 10, 1'b0, 8'h20, 1'b1);
        expectFiller();
        addPkt(0, 8'hAF, 3, 1'b1, 8'h30, 1'b1);
        addPkt(0, 8'h40, 6, 1'b1, 8'h40, 1'b1);
        addPkt(0, 8'h1F, 2, 1'b0, 8'h50, 1'b1);
        expectFiller();
        addPkt(0, 8'h0F, 2, 1'b1, 8'h60, 1'b1);
        addPkt(0, 8'h00, 3, 1'b0, 8'h70, 1'b1);
        expectFiller();
        applyStimulus(0, 8'h2F, 1'b1, 1'b1, 1'b1);
        addPkt(0, 8'h80, 4, 1'b1, 8'h80, 1'b1);
        waitDrain(500);
        checkOutput("trunc_field_cnt", field_cnt, 2);
        checkOutput("trunc_err", err_seen, 3);

        $display("[TB] random back-pressure and valid gaps, mode 2");
        applyReset(2'd2);
        rand_en = 1'b1;
        addField(0, 8'h30, 9, 1'b1);
        addField(1, 8'hB0, 9, 1'b1);
        addField(0, 8'h40, 9, 1'b1);
        waitDrain(2000);
        rand_en = 1'b0;
        checkOutput("rand_field_cnt", field_cnt, 3);
        checkOutput("rand_err", err_seen, 0);

        $display("[TB] reset mid-video");
        applyReset(2'd0);
        addField(0, 8'h50, 30, 1'b1);
        begin
            int n;
            n = 0;
            while (exp_q.size() > 12 && n < 500) begin
                tick();
                n++;
            end
        end
        checkOutput("pre_reset_valid", dout_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("arst_dout_valid", dout_valid, 0);
        checkOutput("arst_dout_data", dout_data, 0);
        checkOutput("arst_dout_sop", dout_startofpacket, 0);
        checkOutput("arst_dout_eop", dout_endofpacket, 0);
        checkOutput("arst_in0_ready", in0_ready, 0);
        exp_q.delete();
        tick();
        tick();
        reset    = 1'b0;
        err_seen = 0;
        addField(0, 8'h70, 5, 1'b1);
        waitDrain(300);
        checkOutput("post_rst_field_cnt", field_cnt, 1);
        checkOutput("post_rst_err", err_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
